// File: rtl/router_out_arbiter.sv
// ---------------------------------------------------------------------------
// router_out_arbiter
//
// Purpose:
//   Output-port stage of a three-port router. Two input ports compete for
//   this output. A round-robin arbiter picks one of them, and the winning
//   47-bit packet is captured, unmodified, in a single output register.
//   The block also keeps a saturating count of grants for each requester.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in0_valid/data/ready  requester 0 handshake (ready = accepted this cycle)
//   in1_valid/data/ready  requester 1 handshake
//   out_valid/data/ready  registered output handshake toward downstream
//   last_grant          index of the most recent winner (1 after reset)
//   grant_cnt0/1        saturating per-requester accepted-packet counters
//   clr_cnt             synchronous clear of both counters (beats increment)
// ---------------------------------------------------------------------------
module router_out_arbiter #(
    parameter int WIDTH = 47,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             last_grant,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1,
    input  logic             clr_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (&c) begin
            return c;
        end
        return c + CNT_ONE;
    endfunction

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] grant_cnt0_q, grant_cnt0_d;
    logic [CNT_W-1:0] grant_cnt1_q, grant_cnt1_d;

    logic load;
    logic win_vld;
    logic win_idx;
    logic xfer0;
    logic xfer1;

    // Arbitration: the register can take a packet when it is empty or is
    // being drained this cycle. On a tie the requester that did not win
    // last time gets the grant. Grants are suppressed during reset so no
    // packet is consumed from a requester while state is being cleared.
    always_comb begin
        load    = !out_valid_q || out_ready;
        win_vld = 1'b0;
        win_idx = 1'b0;
        if (load && !rst) begin
            if (in0_valid && in1_valid) begin
                win_vld = 1'b1;
                win_idx = !last_grant_q;
            end else if (in0_valid) begin
                win_vld = 1'b1;
                win_idx = 1'b0;
            end else if (in1_valid) begin
                win_vld = 1'b1;
                win_idx = 1'b1;
            end
        end
        xfer0 = win_vld && !win_idx;
        xfer1 = win_vld &&  win_idx;
    end

    assign in0_ready = xfer0;
    assign in1_ready = xfer1;

    // Next-state: output register reload, grant history and counters.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        last_grant_d = last_grant_q;
        grant_cnt0_d = grant_cnt0_q;
        grant_cnt1_d = grant_cnt1_q;

        if (load) begin
            out_valid_d = win_vld;
            if (win_vld) begin
                out_data_d   = win_idx ? in1_data : in0_data;
                last_grant_d = win_idx;
            end
        end

        if (clr_cnt) begin
            grant_cnt0_d = '0;
        end else if (xfer0) begin
            grant_cnt0_d = sat_inc(grant_cnt0_q);
        end

        if (clr_cnt) begin
            grant_cnt1_d = '0;
        end else if (xfer1) begin
            grant_cnt1_d = sat_inc(grant_cnt1_q);
        end
    end

    // Register stage: output packet and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            last_grant_q <= 1'b1;
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            last_grant_q <= last_grant_d;
            grant_cnt0_q <= grant_cnt0_d;
            grant_cnt1_q <= grant_cnt1_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign last_grant = last_grant_q;
    assign grant_cnt0 = grant_cnt0_q;
    assign grant_cnt1 = grant_cnt1_q;

endmodule

// File: tb/tb_router_out_arbiter.sv
module tb_router_out_arbiter;

    localparam int WIDTH = 47;
    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in0_valid, in1_valid;
    logic [WIDTH-1:0] in0_data, in1_data;
    logic             in0_ready, in1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             last_grant;
    logic [CNT_W-1:0] grant_cnt0, grant_cnt1;
    logic             clr_cnt;

    router_out_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .last_grant(last_grant), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
        .clr_cnt(clr_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: a one-slot buffer plus "who went last" and counts.
    bit               m_valid;
    logic [WIDTH-1:0] m_data;
    int               m_last;
    int               m_cnt[2];
    int               acc0, acc1;
    int               order_q[$];

    task automatic model_reset();
        m_valid  = 0;
        m_data   = '0;
        m_last   = 1;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
    endtask

    // One clock: check every output against the model at the falling edge,
    // advance the model, then step past the rising edge.
    task automatic cycle();
        bit can_take;
        int win;
        @(negedge clk);
        can_take = !m_valid || out_ready;
        win = -1;
        if (can_take && !rst) begin
            if (in0_valid && in1_valid) win = 1 - m_last;
            else if (in0_valid)         win = 0;
            else if (in1_valid)         win = 1;
        end
        check("in0_ready", 64'(in0_ready), 64'(win == 0));
        check("in1_ready", 64'(in1_ready), 64'(win == 1));
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("out_data", 64'(out_data), 64'(m_data));
        check("last_grant", 64'(last_grant), 64'(m_last));
        check("grant_cnt0", 64'(grant_cnt0), 64'(m_cnt[0]));
        check("grant_cnt1", 64'(grant_cnt1), 64'(m_cnt[1]));
        acc0 = (win == 0);
        acc1 = (win == 1);
        if (win >= 0) order_q.push_back(win);
        if (rst) begin
            model_reset();
        end else begin
            if (can_take) begin
                m_valid = (win >= 0);
                if (win >= 0) begin
                    m_data = (win == 1) ? in1_data : in0_data;
                    m_last = win;
                    if (m_cnt[win] < CNT_MAX) m_cnt[win]++;
                end
            end
            if (clr_cnt) begin
                m_cnt[0] = 0;
                m_cnt[1] = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [WIDTH-1:0] d0,
                         input logic v1, input logic [WIDTH-1:0] d1,
                         input logic ordy);
        in0_valid = v0; in0_data = d0;
        in1_valid = v1; in1_data = d1;
        out_ready = ordy;
    endtask

    logic [WIDTH-1:0] pkt_a, pkt_b, held;
    int exp_order[6] = '{0, 1, 0, 1, 0, 1};
    int exp_sat[5]   = '{1, 2, 3, 3, 3};

    initial begin
        model_reset();
        rst = 1'b1; clr_cnt = 1'b0;
        pkt_a = {3'b001, 3'b010, 41'h0_1234_5678};
        pkt_b = {3'b000, 3'b001, 41'h1_8765_4321};
        #1;

        // Reset with both requesters active: nothing may be accepted.
        drive(1'b1, pkt_a, 1'b1, pkt_b, 1'b1);
        cycle();
        cycle();
        rst = 1'b0;
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        cycle();

        // Single source.
        drive(1'b1, {3'b100, 3'b000, {41{1'b1}}}, 1'b0, '0, 1'b1);
        cycle();
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        check("single_data", 64'(out_data), 64'({3'b100, 3'b000, {41{1'b1}}}));
        check("single_cnt0", 64'(grant_cnt0), 64'd1);
        check("single_last", 64'(last_grant), 64'd0);
        cycle();

        // Streaming contention from a fresh reset.
        rst = 1'b1; cycle(); rst = 1'b0;
        order_q.delete();
        drive(1'b1, pkt_a, 1'b1, pkt_b, 1'b1);
        for (int i = 0; i < 6; i++) cycle();
        check("contend_len", 64'(order_q.size()), 64'd6);
        for (int i = 0; i < 6 && i < order_q.size(); i++)
            check("contend_order", 64'(order_q[i]), 64'(exp_order[i]));
        check("contend_cnt0", 64'(grant_cnt0), 64'd3);
        check("contend_cnt1", 64'(grant_cnt1), 64'd3);

        // Backpressure: register full, downstream stalled, in1 waiting.
        drive(1'b0, '0, 1'b1, pkt_b ^ 47'h5A5A, 1'b0);
        held = out_data;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("bp_hold", 64'(out_data), 64'(held));
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", 64'(in1_ready), 64'd1);
        cycle();
        check("bp_new_data", 64'(out_data), 64'(pkt_b ^ 47'h5A5A));
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        cycle();

        // Saturation and clear priority.
        rst = 1'b1; cycle(); rst = 1'b0;
        drive(1'b1, pkt_a, 1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("sat_cnt0", 64'(grant_cnt0), 64'(exp_sat[i]));
        end
        clr_cnt = 1'b1;
        cycle();
        clr_cnt = 1'b0;
        check("clr_cnt0", 64'(grant_cnt0), 64'd0);

        // Reset while full and stalled: held packet is discarded.
        drive(1'b1, pkt_b, 1'b0, '0, 1'b0);
        cycle();
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        cycle();
        rst = 1'b0;
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        drive(1'b1, pkt_a, 1'b1, pkt_b, 1'b1);
        #1;
        check("rst_mid_tie0", 64'(in0_ready), 64'd1);
        cycle();
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        cycle();

        // Randomized traffic; unaccepted requests are held stable.
        acc0 = 0; acc1 = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!(in0_valid && !acc0)) begin
                in0_valid = ($urandom_range(0, 3) != 0);
                in0_data  = {$urandom(), $urandom()};
            end
            if (!(in1_valid && !acc1)) begin
                in1_valid = ($urandom_range(0, 3) != 0);
                in1_data  = {$urandom(), $urandom()};
            end
            out_ready = ($urandom_range(0, 3) != 0);
            clr_cnt   = ($urandom_range(0, 40) == 0);
            rst       = ($urandom_range(0, 80) == 0);
            if (rst) begin
                in0_valid = 1'b0;
                in1_valid = 1'b0;
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/router_out_arbiter.md
# router_out_arbiter

Clocked two-requester round-robin arbiter and output register for one router output port. Each router output (P_out, C1_out, C2_out) is fed by exactly two of the other input ports: P_out from C1 and C2, C1_out from P and C2, C2_out from P and C1. One instance per output port resolves contention between those two sources, forwards whole 47-bit packets unchanged, and keeps per-source grant statistics.

## Interface
- WIDTH, 47, packet width: dest addr [46:44], source addr [43:41], payload [40:0]
- CNT_W, 16, width of each saturating grant counter
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- in0_valid  in  1  requester 0 has a packet
- in0_data  in  WIDTH  requester 0 packet
- in0_ready  out  1  requester 0 packet accepted this cycle
- in1_valid  in  1  requester 1 has a packet
- in1_data  in  WIDTH  requester 1 packet
- in1_ready  out  1  requester 1 packet accepted this cycle
- out_valid  out  1  output register holds a packet
- out_data  out  WIDTH  output packet
- out_ready  in  1  downstream accepts out_data this cycle
- last_grant  out  1  index of the most recent winner
- grant_cnt0  out  CNT_W  packets accepted from requester 0
- grant_cnt1  out  CNT_W  packets accepted from requester 1
- clr_cnt  in  1  synchronous clear of both grant counters

## Operation
- Transfer rule: a transfer occurs on a port when valid && ready at a rising edge. Packets are single-beat and are never modified, split or dropped.
- Output register states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- Load enable: load = !out_valid || out_ready. The register accepts a new packet whenever it is empty or is being drained in the same cycle.
- Arbitration (combinational, evaluated only when load=1):
  - Only in0_valid: winner is 0.
  - Only in1_valid: winner is 1.
  - Both valid: winner is !last_grant.
  - Neither valid: no winner.
- Ready outputs:
  - inX_ready = load && (winner==X).
  - At most one inX_ready is high in any cycle.
  - The losing requester's ready stays 0.
  - Requesters must hold valid and data stable until accepted.
- State transitions:
  - EMPTY with a winner → FULL. out_data is loaded from the winner and last_grant is updated to the winner.
  - FULL with out_ready=1 and a winner → FULL. The register is reloaded in the same cycle, so there is no bubble.
  - FULL with out_ready=1 and no winner → EMPTY.
  - FULL with out_ready=0 → FULL. out_data is held, both inX_ready are 0, and last_grant is unchanged.
- Counters:
  - grant_cntX increments by 1 on each requester-X transfer.
  - The counter saturates at 2^CNT_W−1 and does not wrap.
  - clr_cnt has priority over an increment in the same cycle; the counter becomes 0.
- Reset sets:
  - out_valid=0.
  - out_data=0.
  - last_grant=1, so requester 0 wins the first tie.
  - grant_cnt0=grant_cnt1=0.
  - in0_ready=in1_ready=0 in the reset cycle.
  - Reset mid-transfer discards the held packet. A requester that was not yet granted must re-present its packet.

## Timing
- Latency: 1 cycle from input acceptance to out_valid=1 with that packet.
- Throughput: 1 packet/cycle when out_ready is held at 1.
- Fairness under continuous contention: grants strictly alternate 0,1,0,1…. Worst-case wait for a requester is 1 grant of the other requester.
- out_valid and out_data are registered. Once out_valid=1, it is never deasserted and out_data never changes until out_ready=1.
- Combinational paths:
  - inX_ready depends combinationally on out_ready, in0_valid and in1_valid.
  - No combinational path exists from inX_data to any output.
- Counter and last_grant updates are visible the cycle after the transfer.

## Test plan
- Reset sequence: drive rst=1 for 2 cycles with both valids high → out_valid=0, out_data=0, both ready=0, counters=0, last_grant=1.
- Single source:
  - Stimulus: in0 presents {3'b100,3'b000,{41{1'b1}}} with out_ready=1.
  - Required response: in0_ready=1 that cycle; next cycle out_valid=1 and out_data equals that packet; grant_cnt0=1; last_grant=0.
- Contention, streaming:
  - Stimulus: both valids held for 6 cycles with out_ready=1; in0_data=dest 001, in1_data=dest 000.
  - Required response: accept order 0,1,0,1,0,1 with no bubbles; grant_cnt0=grant_cnt1=3.
- Backpressure:
  - Stimulus: register FULL, out_ready=0 for 4 cycles, in1_valid=1.
  - Required response: out_data stable, in1_ready=0 throughout.
  - Then raise out_ready for 1 cycle → in1 is accepted in that same cycle, and out_data updates the next cycle.
- Counter saturation and clear:
  - Stimulus: CNT_W=2 with 5 in0 transfers.
  - Required response: grant_cnt0 reads 1,2,3,3,3.
  - Then assert clr_cnt together with an in0 transfer → grant_cnt0=0.
- Reset mid-operation:
  - Stimulus: assert rst while FULL with out_ready=0.
  - Required response: out_valid=0 the next cycle; the held packet is never emitted; first tie after reset is won by requester 0.
